control_unit: RTL and testbench

//  Instruction sequencer that drives the basic-computer datapath's control strobes.

---
 rtl/cu_pkg.sv | 61 ++++++
 rtl/control_unit_if.sv | 34 +++
 rtl/cu_decoder.sv | 59 +++++
 rtl/control_unit.sv | 139 +++++++++++++
 tb/tb_control_unit.sv | 280 ++++++++++++++++++++++++++++
 5 files changed

// File: rtl/cu_pkg.sv
// Shared definitions for the basic-computer control unit: opcodes, register-reference
// subops, op-strobe vector layout and the sequencer state encoding.
package cu_pkg;

    localparam logic [2:0] OP_ADD = 3'b001;
    localparam logic [2:0] OP_LDA = 3'b010;
    localparam logic [2:0] OP_STA = 3'b011;
    localparam logic [2:0] OP_BUN = 3'b100;
    localparam logic [2:0] OP_ISZ = 3'b110;
    localparam logic [2:0] OP_REG = 3'b111;

    localparam logic [3:0] SUB_CLA = 4'd0;
    localparam logic [3:0] SUB_CLE = 4'd1;
    localparam logic [3:0] SUB_CMA = 4'd2;
    localparam logic [3:0] SUB_LDI = 4'd3;
    localparam logic [3:0] SUB_CIR = 4'd4;
    localparam logic [3:0] SUB_CIL = 4'd5;
    localparam logic [3:0] SUB_INC = 4'd6;
    localparam logic [3:0] SUB_HLT = 4'd7;

    localparam int NUM_OPS = 12;
    localparam int OPV_CLA = 0;
    localparam int OPV_CLE = 1;
    localparam int OPV_CMA = 2;
    localparam int OPV_LDI = 3;
    localparam int OPV_CIR = 4;
    localparam int OPV_CIL = 5;
    localparam int OPV_INC = 6;
    localparam int OPV_ADD = 7;
    localparam int OPV_LDA = 8;
    localparam int OPV_STA = 9;
    localparam int OPV_BUN = 10;
    localparam int OPV_ISZ = 11;

    typedef logic [NUM_OPS-1:0] opvec_t;

    typedef enum logic [2:0] {
        S_HALT   = 3'd0,
        S_FETCH  = 3'd1,
        S_DECODE = 3'd2,
        S_INDIR  = 3'd3,
        S_ADDR   = 3'd4,
        S_OPRD   = 3'd5,
        S_EXEC   = 3'd6
    } state_t;

    typedef struct packed {
        logic   fetch;
        logic   read;
        logic   write;
        logic   is_ind;
        logic   is_dir;
        logic   execute;
        opvec_t ops;
    } strobe_t;

    function automatic logic [3:0] sat_inc4(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

endpackage

// File: rtl/control_unit_if.sv
// Control-unit <-> datapath bundle. The control unit is the master: it samples
// i_start/i_ir/i_ex_done and drives every strobe plus status/debug state.
interface control_unit_if;
    import cu_pkg::*;

    logic        i_start;
    logic [15:0] i_ir;
    logic        i_ex_done;

    logic o_fetch, o_read, o_write, o_is_ind, o_is_dir, o_execute;
    logic o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac;
    logic o_add, o_load, o_store, o_branch, o_isz;
    logic       o_halt;
    logic       o_err;
    logic [3:0] o_sc;
    state_t     o_dbg_state;

    modport master (
        input  i_start, i_ir, i_ex_done,
        output o_fetch, o_read, o_write, o_is_ind, o_is_dir, o_execute,
        output o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
        output o_add, o_load, o_store, o_branch, o_isz,
        output o_halt, o_err, o_sc, o_dbg_state
    );

    modport slave (
        output i_start, i_ir, i_ex_done,
        input  o_fetch, o_read, o_write, o_is_ind, o_is_dir, o_execute,
        input  o_clr_ac, o_clr_e, o_comp_ac, o_load_ac, o_cir_r, o_cir_l, o_inc_ac,
        input  o_add, o_load, o_store, o_branch, o_isz,
        input  o_halt, o_err, o_sc, o_dbg_state
    );

endinterface

// File: rtl/cu_decoder.sv
// Combinational instruction decode of the IR high byte {I, op[2:0], subop[3:0]}
// into a one-hot op vector and the class flags that steer the sequencer.
module cu_decoder
    import cu_pkg::*;
(
    input  logic [7:0] i_ir_hi,
    output opvec_t     o_ops,
    output logic       o_is_reg,
    output logic       o_is_mem,
    output logic       o_needs_oprd,
    output logic       o_is_nop,
    output logic       o_is_hlt
);

    logic       w_ind;
    logic [2:0] w_op;
    logic [3:0] w_sub;

    assign w_ind = i_ir_hi[7];
    assign w_op  = i_ir_hi[6:4];
    assign w_sub = i_ir_hi[3:0];

    always_comb begin
        o_ops        = '0;
        o_is_reg     = 1'b0;
        o_is_mem     = 1'b0;
        o_needs_oprd = 1'b0;
        o_is_nop     = 1'b0;
        o_is_hlt     = 1'b0;
        case (w_op)
            OP_ADD: begin o_ops[OPV_ADD] = 1'b1; o_is_mem = 1'b1; o_needs_oprd = 1'b1; end
            OP_LDA: begin o_ops[OPV_LDA] = 1'b1; o_is_mem = 1'b1; o_needs_oprd = 1'b1; end
            OP_STA: begin o_ops[OPV_STA] = 1'b1; o_is_mem = 1'b1; end
            OP_BUN: begin o_ops[OPV_BUN] = 1'b1; o_is_mem = 1'b1; end
            OP_ISZ: begin o_ops[OPV_ISZ] = 1'b1; o_is_mem = 1'b1; o_needs_oprd = 1'b1; end
            OP_REG: begin
                // The I bit set on op 111 would be I/O-reference, which this machine lacks.
                if (w_ind) begin
                    o_is_nop = 1'b1;
                end else begin
                    o_is_reg = 1'b1;
                    case (w_sub)
                        SUB_CLA: o_ops[OPV_CLA] = 1'b1;
                        SUB_CLE: o_ops[OPV_CLE] = 1'b1;
                        SUB_CMA: o_ops[OPV_CMA] = 1'b1;
                        SUB_LDI: o_ops[OPV_LDI] = 1'b1;
                        SUB_CIR: o_ops[OPV_CIR] = 1'b1;
                        SUB_CIL: o_ops[OPV_CIL] = 1'b1;
                        SUB_INC: o_ops[OPV_INC] = 1'b1;
                        SUB_HLT: begin o_is_reg = 1'b0; o_is_hlt = 1'b1; end
                        default: begin o_is_reg = 1'b0; o_is_nop = 1'b1; end
                    endcase
                end
            end
            default: o_is_nop = 1'b1;
        endcase
    end

endmodule

// File: rtl/control_unit.sv
// Instruction sequencer: HALT/FETCH/DECODE/INDIR/ADDR/OPRD/EXEC with an execute
// timeout; every output is registered from the next-state decision.
module control_unit
    import cu_pkg::*;
#(
    parameter int unsigned EX_TIMEOUT = 15
) (
    input  logic           clk,
    input  logic           i_clr_reg,
    control_unit_if.master io_bus
);

    localparam logic [3:0] EX_LAST = 4'(EX_TIMEOUT - 1);

    state_t     r_state, w_next_state;
    logic [7:0] r_ir_q;
    logic [3:0] r_ex_cnt, w_next_ex_cnt;
    logic [3:0] r_sc, w_next_sc;
    logic       r_err, w_next_err;
    logic       r_halt, w_next_halt;
    strobe_t    r_out, w_next_out;

    logic [7:0] w_dec_ir;
    opvec_t     w_ops;
    logic       w_is_reg, w_is_mem, w_needs_oprd, w_is_nop, w_is_hlt;

    // Only the I/op/subop byte steers sequencing; the address field stays in the datapath.
    assign w_dec_ir = (r_state == S_DECODE) ? io_bus.i_ir[15:8] : r_ir_q;

    cu_decoder u_decoder (
        .i_ir_hi      (w_dec_ir),
        .o_ops        (w_ops),
        .o_is_reg     (w_is_reg),
        .o_is_mem     (w_is_mem),
        .o_needs_oprd (w_needs_oprd),
        .o_is_nop     (w_is_nop),
        .o_is_hlt     (w_is_hlt)
    );

    // Handshake: EXEC strobes stay asserted each cycle until i_ex_done is sampled high
    // on a rising edge; i_ex_done is a don't-care in every other state.
    always_comb begin
        w_next_state  = r_state;
        w_next_err    = r_err;
        w_next_ex_cnt = '0;
        case (r_state)
            S_HALT:   if (io_bus.i_start) w_next_state = S_FETCH;
            S_FETCH:  w_next_state = S_DECODE;
            S_DECODE: begin
                unique case (1'b1)
                    w_is_hlt: w_next_state = S_HALT;
                    w_is_reg: w_next_state = S_EXEC;
                    w_is_mem: w_next_state = w_dec_ir[7] ? S_INDIR : S_ADDR;
                    w_is_nop: w_next_state = S_FETCH;
                    default:  w_next_state = S_FETCH;
                endcase
            end
            S_INDIR, S_ADDR: w_next_state = w_needs_oprd ? S_OPRD : S_EXEC;
            S_OPRD:   w_next_state = S_EXEC;
            S_EXEC: begin
                if (io_bus.i_ex_done) begin
                    w_next_state = S_FETCH;
                end else if (r_ex_cnt == EX_LAST) begin
                    w_next_state = S_FETCH;
                    w_next_err   = 1'b1;
                end else begin
                    w_next_ex_cnt = r_ex_cnt + 4'd1;
                end
            end
            default:  w_next_state = S_HALT;
        endcase

        w_next_out  = '0;
        w_next_halt = 1'b0;
        case (w_next_state)
            S_HALT:  w_next_halt = 1'b1;
            S_FETCH: begin w_next_out.fetch  = 1'b1; w_next_out.read = 1'b1; end
            S_INDIR: begin w_next_out.is_ind = 1'b1; w_next_out.read = 1'b1; end
            S_ADDR:  w_next_out.is_dir = 1'b1;
            S_OPRD:  w_next_out.read   = 1'b1;
            S_EXEC: begin
                w_next_out.execute = 1'b1;
                w_next_out.ops     = w_ops;
                w_next_out.write   = w_ops[OPV_STA];
            end
            default: ;
        endcase

        case (w_next_state)
            S_FETCH: w_next_sc = '0;
            S_HALT:  w_next_sc = r_sc;
            default: w_next_sc = sat_inc4(r_sc);
        endcase
    end

    always_ff @(posedge clk) begin
        if (i_clr_reg) begin
            r_state  <= S_HALT;
            r_ir_q   <= '0;
            r_ex_cnt <= '0;
            r_sc     <= '0;
            r_err    <= 1'b0;
            r_halt   <= 1'b1;
            r_out    <= '0;
        end else begin
            r_state  <= w_next_state;
            r_ex_cnt <= w_next_ex_cnt;
            r_sc     <= w_next_sc;
            r_err    <= w_next_err;
            r_halt   <= w_next_halt;
            r_out    <= w_next_out;
            if (r_state == S_DECODE) r_ir_q <= io_bus.i_ir[15:8];
        end
    end

    assign io_bus.o_fetch     = r_out.fetch;
    assign io_bus.o_read      = r_out.read;
    assign io_bus.o_write     = r_out.write;
    assign io_bus.o_is_ind    = r_out.is_ind;
    assign io_bus.o_is_dir    = r_out.is_dir;
    assign io_bus.o_execute   = r_out.execute;
    assign io_bus.o_clr_ac    = r_out.ops[OPV_CLA];
    assign io_bus.o_clr_e     = r_out.ops[OPV_CLE];
    assign io_bus.o_comp_ac   = r_out.ops[OPV_CMA];
    assign io_bus.o_load_ac   = r_out.ops[OPV_LDI];
    assign io_bus.o_cir_r     = r_out.ops[OPV_CIR];
    assign io_bus.o_cir_l     = r_out.ops[OPV_CIL];
    assign io_bus.o_inc_ac    = r_out.ops[OPV_INC];
    assign io_bus.o_add       = r_out.ops[OPV_ADD];
    assign io_bus.o_load      = r_out.ops[OPV_LDA];
    assign io_bus.o_store     = r_out.ops[OPV_STA];
    assign io_bus.o_branch    = r_out.ops[OPV_BUN];
    assign io_bus.o_isz       = r_out.ops[OPV_ISZ];
    assign io_bus.o_halt      = r_halt;
    assign io_bus.o_err       = r_err;
    assign io_bus.o_sc        = r_sc;
    assign io_bus.o_dbg_state = r_state;

endmodule

// File: tb/tb_control_unit.sv
// Bench for control_unit: directed cycle table for the documented sequences, then
// randomized instruction streams checked against an instruction-level model.
module tb_control_unit;

    localparam int EX_T    = 4;
    localparam int W       = 24;
    localparam int OPI_STA = 9;
    localparam logic [15:0] GARB = 16'hFFFF;

    logic clk = 1'b0;
    logic r_clr;

    control_unit_if cu_if ();

    control_unit #(.EX_TIMEOUT(EX_T)) dut (
        .clk       (clk),
        .i_clr_reg (r_clr),
        .io_bus    (cu_if)
    );

    always #5 clk = ~clk;

    typedef enum int {P_HALT, P_FETCH, P_DECODE, P_INDIR, P_ADDR, P_OPRD, P_EXEC} ph_t;

    typedef struct {
        logic        clr;
        logic        start;
        logic        done;
        logic [15:0] ir;
    } stim_t;

    typedef struct {
        logic        clr;
        logic        start;
        logic        done;
        logic [15:0] ir;
        logic [W-1:0] exp;
        string       tag;
    } vec_t;

    logic [W-1:0] exp_q[$];
    stim_t        stim_q[$];
    string        tag_q[$];
    vec_t         vecs[$];

    int n_vec = 0;
    int n_bad = 0;

    bit m_halted;
    bit m_err;
    int m_sc_halt;

    // Memory-reference op -> bench op index (ADD=7, LDA=8, STA=9, BUN=10, ISZ=11).
    int mem_opi [8] = '{-1, 7, 8, 9, 10, -1, 11, -1};

    // Expected output vector {fetch,read,write,is_ind,is_dir,execute, ops[11:0], halt, err, sc}
    // where ops[0..11] = clr_ac, clr_e, comp_ac, load_ac, cir_r, cir_l, inc_ac, add, load, store, branch, isz.
    function automatic logic [W-1:0] ex(input ph_t ph, input int opi, input bit err, input int sc);
        logic [5:0]  ph_s;
        logic [11:0] ops;
        logic        halt;
        int          s;
        ph_s = '0;
        ops  = '0;
        halt = 1'b0;
        s    = (sc > 15) ? 15 : sc;
        case (ph)
            P_HALT:   halt = 1'b1;
            P_FETCH:  ph_s = 6'b110000;
            P_INDIR:  ph_s = 6'b010100;
            P_ADDR:   ph_s = 6'b000010;
            P_OPRD:   ph_s = 6'b010000;
            P_EXEC: begin
                ph_s = 6'b000001;
                if (opi >= 0) ops[opi] = 1'b1;
                if (opi == OPI_STA) ph_s[3] = 1'b1;
            end
            default: ;
        endcase
        return {ph_s, ops, halt, err, 4'(s)};
    endfunction

    function automatic logic [W-1:0] got_vec();
        return {cu_if.o_fetch, cu_if.o_read, cu_if.o_write, cu_if.o_is_ind, cu_if.o_is_dir,
                cu_if.o_execute, cu_if.o_isz, cu_if.o_branch, cu_if.o_store, cu_if.o_load,
                cu_if.o_add, cu_if.o_inc_ac, cu_if.o_cir_l, cu_if.o_cir_r, cu_if.o_load_ac,
                cu_if.o_comp_ac, cu_if.o_clr_e, cu_if.o_clr_ac, cu_if.o_halt, cu_if.o_err,
                cu_if.o_sc};
    endfunction

    task automatic check(input logic [W-1:0] e, input string tag);
        logic [W-1:0] g;
        g = got_vec();
        n_vec++;
        if (g !== e) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, g, e);
        end
    endtask

    task automatic drive(input stim_t s);
        r_clr           = s.clr;
        cu_if.i_start   = s.start;
        cu_if.i_ex_done = s.done;
        cu_if.i_ir      = s.ir;
    endtask

    task automatic addv(input logic clr, input logic start, input logic done,
                        input logic [15:0] ir, input logic [W-1:0] e, input string tag);
        vec_t v;
        v.clr = clr; v.start = start; v.done = done; v.ir = ir; v.exp = e; v.tag = tag;
        vecs.push_back(v);
    endtask

    task automatic push_cyc(input logic [W-1:0] e, input stim_t s, input string tag);
        exp_q.push_back(e);
        stim_q.push_back(s);
        tag_q.push_back(tag);
    endtask

    task automatic plan_halt(input int idx, input int n_wait);
        stim_t s;
        for (int i = 0; i <= n_wait; i++) begin
            s.clr   = 1'b0;
            s.start = (i == n_wait);
            s.done  = 1'($urandom);
            s.ir    = 16'($urandom);
            push_cyc(ex(P_HALT, -1, m_err, m_sc_halt), s, $sformatf("i%0d_HALT", idx));
        end
        m_halted = 1'b0;
    endtask

    // One instruction from its FETCH: done_at = EXEC cycle that sees done (0 = never),
    // clr_at = cycle offset from FETCH at which reset is asserted (-1 = none).
    task automatic plan_instr(input int idx, input logic [15:0] instr, input int done_at, input int clr_at);
        ph_t   phs[$];
        int    opi, op, sub, exec_k, n_exec;
        bit    ind, hlt, nop;
        stim_t s;
        ind = instr[15];
        op  = int'(instr[14:12]);
        sub = int'(instr[11:8]);
        opi = -1; hlt = 1'b0; nop = 1'b0;
        if (op == 7 && !ind) begin
            if (sub == 7)     hlt = 1'b1;
            else if (sub < 7) opi = sub;
            else              nop = 1'b1;
        end else if (mem_opi[op] >= 0) begin
            opi = mem_opi[op];
        end else begin
            nop = 1'b1;
        end
        phs.push_back(P_FETCH);
        phs.push_back(P_DECODE);
        if (!hlt && !nop) begin
            if (op != 7) begin
                phs.push_back(ind ? P_INDIR : P_ADDR);
                if (opi == 7 || opi == 8 || opi == 11) phs.push_back(P_OPRD);
            end
            n_exec = (done_at == 0) ? EX_T : done_at;
            for (int k = 0; k < n_exec; k++) phs.push_back(P_EXEC);
        end
        exec_k = 0;
        foreach (phs[p]) begin
            s.ir    = (phs[p] == P_DECODE) ? instr : 16'($urandom);
            s.start = 1'($urandom);
            s.clr   = (p == clr_at);
            if (phs[p] == P_EXEC) begin
                exec_k++;
                s.done = (exec_k == done_at);
            end else begin
                s.done = 1'($urandom);
            end
            push_cyc(ex(phs[p], opi, m_err, p), s, $sformatf("i%0d_%s", idx, phs[p].name()));
            if (s.clr) begin
                m_err     = 1'b0;
                m_halted  = 1'b1;
                m_sc_halt = 0;
                return;
            end
        end
        if (hlt) begin
            m_halted  = 1'b1;
            m_sc_halt = 1;
        end
        if (!hlt && !nop && done_at == 0) m_err = 1'b1;
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "time limit");
    end

    initial begin
        logic [15:0] ir;
        int          done_at, clr_at;
        stim_t       s;

        r_clr           = 1'b1;
        cu_if.i_start   = 1'b0;
        cu_if.i_ir      = '0;
        cu_if.i_ex_done = 1'b0;

        addv(0, 1, 0, GARB,    ex(P_HALT,   -1, 0, 0), "reset");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "cma_fetch");
        addv(0, 0, 0, 16'h7200, ex(P_DECODE, -1, 0, 1), "cma_decode");
        addv(0, 0, 1, GARB,    ex(P_EXEC,    2, 0, 2), "cma_exec");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "cma_refetch");
        addv(0, 0, 0, 16'h1123, ex(P_DECODE, -1, 0, 1), "add_decode");
        addv(0, 0, 1, 16'h0000, ex(P_ADDR,   -1, 0, 2), "add_addr");
        addv(0, 0, 1, GARB,    ex(P_OPRD,   -1, 0, 3), "add_oprd");
        addv(0, 0, 0, GARB,    ex(P_EXEC,    7, 0, 4), "add_exec1");
        addv(0, 0, 0, GARB,    ex(P_EXEC,    7, 0, 5), "add_exec2");
        addv(0, 0, 1, GARB,    ex(P_EXEC,    7, 0, 6), "add_exec3");
        addv(0, 1, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "sta_fetch");
        addv(0, 0, 0, 16'hB050, ex(P_DECODE, -1, 0, 1), "sta_decode");
        addv(0, 0, 0, GARB,    ex(P_INDIR,  -1, 0, 2), "sta_indir");
        addv(0, 0, 1, GARB,    ex(P_EXEC,    9, 0, 3), "sta_exec");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "hlt_fetch");
        addv(0, 0, 0, 16'h7700, ex(P_DECODE, -1, 0, 1), "hlt_decode");
        addv(0, 0, 1, GARB,    ex(P_HALT,   -1, 0, 1), "hlt_halt1");
        addv(0, 0, 0, GARB,    ex(P_HALT,   -1, 0, 1), "hlt_halt2");
        addv(0, 1, 0, GARB,    ex(P_HALT,   -1, 0, 1), "hlt_halt3");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "to_fetch");
        addv(0, 0, 0, 16'h4000, ex(P_DECODE, -1, 0, 1), "to_decode");
        addv(0, 0, 0, GARB,    ex(P_ADDR,   -1, 0, 2), "to_addr");
        addv(0, 0, 0, GARB,    ex(P_EXEC,   10, 0, 3), "to_exec1");
        addv(0, 0, 0, GARB,    ex(P_EXEC,   10, 0, 4), "to_exec2");
        addv(0, 0, 0, GARB,    ex(P_EXEC,   10, 0, 5), "to_exec3");
        addv(0, 0, 0, GARB,    ex(P_EXEC,   10, 0, 6), "to_exec4");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 1, 0), "to_err_fetch");
        addv(0, 0, 0, 16'h2345, ex(P_DECODE, -1, 1, 1), "clr_decode");
        addv(0, 0, 0, GARB,    ex(P_ADDR,   -1, 1, 2), "clr_addr");
        addv(1, 1, 1, GARB,    ex(P_OPRD,   -1, 1, 3), "clr_oprd");
        addv(0, 0, 0, GARB,    ex(P_HALT,   -1, 0, 0), "clr_halt");
        addv(0, 1, 0, GARB,    ex(P_HALT,   -1, 0, 0), "clr_restart");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "nop0_fetch");
        addv(0, 0, 0, 16'h0000, ex(P_DECODE, -1, 0, 1), "nop0_decode");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "nopf_fetch");
        addv(0, 0, 0, 16'hF000, ex(P_DECODE, -1, 0, 1), "nopf_decode");
        addv(0, 0, 0, GARB,    ex(P_FETCH,  -1, 0, 0), "cle_fetch");
        addv(0, 0, 0, 16'h7100, ex(P_DECODE, -1, 0, 1), "cle_decode");
        addv(0, 0, 0, GARB,    ex(P_EXEC,    1, 0, 2), "cle_exec1");
        addv(0, 0, 0, GARB,    ex(P_EXEC,    1, 0, 3), "cle_exec2");
        addv(0, 0, 0, GARB,    ex(P_EXEC,    1, 0, 4), "cle_exec3");
        addv(0, 0, 1, GARB,    ex(P_EXEC,    1, 0, 5), "cle_exec4");

        repeat (2) @(posedge clk);
        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            check(vecs[i].exp, vecs[i].tag);
            s.clr = vecs[i].clr; s.start = vecs[i].start; s.done = vecs[i].done; s.ir = vecs[i].ir;
            drive(s);
        end

        // Table leaves the DUT entering FETCH with no sticky error.
        m_halted  = 1'b0;
        m_err     = 1'b0;
        m_sc_halt = 0;
        for (int n = 0; n < 300; n++) begin
            if (m_halted) plan_halt(n, $urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) ir = {4'h7, 4'($urandom_range(0, 7)), 8'($urandom)};
            else                           ir = 16'($urandom);
            done_at = $urandom_range(0, EX_T);
            clr_at  = ($urandom_range(0, 11) == 0) ? $urandom_range(0, 7) : -1;
            plan_instr(n, ir, done_at, clr_at);
        end

        while (exp_q.size() > 0) begin
            @(negedge clk);
            check(exp_q.pop_front(), tag_q.pop_front());
            drive(stim_q.pop_front());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
